apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter: WIDTH, 32, address and data width of both the command side and the APB side.
REQ-002 Parameter: TIMEOUT, 16, maximum number of ACCESS cycles with PREADY low before the transfer is aborted; legal range 2..255.
REQ-003 PCLK  input  1  clock; all state changes on its rising edge.
REQ-004 PRESETn  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  input  1  a command is presented.
REQ-006 cmd_ready  output  1  the block accepts a command this cycle.
REQ-007 cmd_write  input  1  1 = APB write, 0 = APB read.
REQ-008 cmd_addr  input  WIDTH  target APB address.
REQ-009 cmd_wdata  input  WIDTH  write data; ignored for reads.
REQ-010 rsp_valid  output  1  single-cycle pulse marking transfer completion.
REQ-011 rsp_rdata  output  WIDTH  read data; valid while rsp_valid=1.
REQ-012 rsp_err  output  1  1 = transfer aborted by timeout; valid while rsp_valid=1.
REQ-013 busy  output  1  a transfer is in progress (state SETUP or ACCESS).
REQ-014 PSEL, PENABLE, PWRITE  output  1 each  APB control outputs.
REQ-015 PADDR, PWDATA  output  WIDTH each  APB address and write data.
REQ-016 PRDATA  input  WIDTH; PREADY  input  1  responses from the APB completer.

Function
REQ-017 The state machine SHALL have three states: IDLE, SETUP and ACCESS.
REQ-018 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a clock edge where cmd_valid=1 and cmd_ready=1.
REQ-019 On acceptance, the block SHALL register cmd_addr, cmd_wdata and cmd_write into PADDR, PWDATA and PWRITE, then go to SETUP.
REQ-020 In SETUP: PSEL=1 and PENABLE=0; next state is always ACCESS.
REQ-021 In ACCESS: PSEL=1 and PENABLE=1; PREADY is sampled on every edge.
REQ-022 PADDR, PWRITE and PWDATA SHALL stay constant from SETUP through the last ACCESS cycle, and SHALL keep their values after the transfer until the next acceptance.
REQ-023 ACCESS with PREADY=1 SHALL complete the transfer and go to IDLE.
  - Next cycle: rsp_valid=1 and rsp_err=0.
  - Reads: rsp_rdata = PRDATA sampled at the completing edge.
  - Writes: rsp_rdata = 0.
REQ-024 The wait counter SHALL clear on entry to SETUP and increment on each ACCESS edge where PREADY=0.
REQ-025 When the wait counter reaches TIMEOUT, the block SHALL abort.
  - Go to IDLE; PSEL=0 and PENABLE=0 in the next cycle.
  - That cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-026 If PREADY=1 on the same edge the count would reach TIMEOUT, completion SHALL win: rsp_err=0.
REQ-027 rsp_valid, rsp_rdata and rsp_err SHALL be registered; rsp_valid SHALL stay high for exactly one cycle.
  - rsp_rdata and rsp_err SHALL hold until the next response.
REQ-028 A command SHALL be accepted in the same cycle rsp_valid=1, because that cycle is IDLE.
  - Minimum period is 3 cycles per transfer: accept, SETUP, ACCESS.
REQ-029 PSEL=0 and PENABLE=0 SHALL hold in IDLE; PENABLE SHALL never be 1 while PSEL=0.
REQ-030 A command presented while busy=1 SHALL not be accepted; it stays pending and is not lost.
REQ-031 Latency SHALL be 3 + W cycles from the accepting edge to the rsp_valid edge, where W is the number of wait states.
REQ-032 Illegal state encodings SHALL return to IDLE on the next edge.

Reset
REQ-033 PRESETn=0 SHALL immediately force the state to IDLE.
  - Zero: PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, busy, wait counter.
  - cmd_ready=1.
REQ-034 Reset during SETUP or ACCESS SHALL abandon the transfer with no rsp_valid pulse; the first edge after release SHALL sample from IDLE.

Verification
REQ-035 Zero-wait write: cmd_write=1, addr 0x0000_0002, wdata 0x0000_00A5, PREADY=1.
  - PSEL=1 one cycle after acceptance; PENABLE=1 one cycle later; PADDR=0x2 and PWDATA=0xA5 throughout.
  - rsp_valid 3 cycles after acceptance with rsp_err=0 and rsp_rdata=0.
REQ-036 Read with 2 wait states: addr 0x0000_0001, PREADY low for 2 ACCESS cycles, then high with PRDATA=0x0000_000F.
  - ACCESS lasts 3 cycles; rsp_rdata=0x0000_000F and rsp_err=0.
REQ-037 Timeout: PREADY held 0 with TIMEOUT=16.
  - PSEL and PENABLE drop after 16 ACCESS cycles; rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - A following command completes normally.
REQ-038 Back-to-back: cmd_valid held high for 3 reads.
  - Acceptances occur every 3 cycles, each coinciding with the previous rsp_valid.
  - No cycle has PSEL=1 with PENABLE=1 without a preceding SETUP cycle.
REQ-039 Busy stall: cmd_valid asserted during ACCESS with new addr 0x4.
  - cmd_ready=0 until IDLE; the pending command is accepted on the rsp_valid cycle and PADDR becomes 0x4.
REQ-040 Reset mid-transfer: PRESETn pulsed low during the second ACCESS wait cycle.
  - All outputs return to reset values asynchronously; no rsp_valid pulse.
  - The next command completes normally.

Source files
------------

// File: rtl/apb_master_if.sv
// ============================================================================
// apb_master_if: command, response and APB bus signals of apb_master. Rev 1.0
// ============================================================================
`default_nettype none

interface apb_master_if #(
  parameter int WIDTH = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_write;
  logic [WIDTH-1:0] cmd_addr;
  logic [WIDTH-1:0] cmd_wdata;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_rdata;
  logic             rsp_err;
  logic             busy;
  logic             PSEL;
  logic             PENABLE;
  logic             PWRITE;
  logic [WIDTH-1:0] PADDR;
  logic [WIDTH-1:0] PWDATA;
  logic [WIDTH-1:0] PRDATA;
  logic             PREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

`default_nettype wire

// File: rtl/apb_master.sv
// ============================================================================
// apb_master: single-outstanding APB requester with wait-state timeout. Rev 1.0
// ============================================================================
`default_nettype none

module apb_master #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  wire logic     PCLK,
  input  wire logic     PRESETn,
  apb_master_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_e           state_q,     state_d;
  logic [7:0]       wait_cnt_q,  wait_cnt_d;
  logic             pwrite_q,    pwrite_d;
  logic [WIDTH-1:0] paddr_q,     paddr_d;
  logic [WIDTH-1:0] pwdata_q,    pwdata_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q,   rsp_err_d;
  logic [7:0]       wait_inc;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    wait_inc    = wait_cnt_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          paddr_d    = bus.cmd_addr;
          pwdata_d   = bus.cmd_wdata;
          pwrite_d   = bus.cmd_write;
          wait_cnt_d = 8'd0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // PREADY is checked first so a completion on the final allowed cycle beats the timeout
        if (bus.PREADY) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
        end else if (wait_inc == TIMEOUT_CNT) begin
          wait_cnt_d  = wait_inc;
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 8'd0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Bus controls decode straight from the state register, so PENABLE can never lead PSEL
  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.busy      = (state_q == SETUP) || (state_q == ACCESS);
  assign bus.PSEL      = (state_q == SETUP) || (state_q == ACCESS);
  assign bus.PENABLE   = (state_q == ACCESS);
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_master.sv
// ============================================================================
// tb_apb_master: vector table, random traffic and corner sequences for apb_master. Rev 1.0
// ============================================================================
`default_nettype none

module tb_apb_master;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  apb_master_if #(.WIDTH(WIDTH)) bus();

  apb_master #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .PCLK    (clk),
    .PRESETn (rst_n),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Bus protocol watcher: PENABLE only after SETUP, stable request fields, one-cycle rsp_valid
  int   viol       = 0;
  logic prev_psel  = 1'b0;
  logic prev_rsp   = 1'b0;
  logic prev_wr    = 1'b0;
  logic [WIDTH-1:0] prev_addr  = '0;
  logic [WIDTH-1:0] prev_wdata = '0;
  always @(negedge clk) begin
    if ((bus.PENABLE && !bus.PSEL) ||
        (bus.PSEL && bus.PENABLE && !prev_psel) ||
        (bus.PSEL && prev_psel && (bus.PADDR !== prev_addr || bus.PWDATA !== prev_wdata ||
                                   bus.PWRITE !== prev_wr)) ||
        (bus.rsp_valid && prev_rsp) ||
        (bus.PSEL !== bus.busy) || (bus.cmd_ready === bus.busy))
      viol <= viol + 1;
    prev_psel  <= bus.PSEL;
    prev_rsp   <= bus.rsp_valid;
    prev_wr    <= bus.PWRITE;
    prev_addr  <= bus.PADDR;
    prev_wdata <= bus.PWDATA;
  end

  // Expected outcome of one transfer from its wait-state count
  function automatic void ref_model(input logic wr, input int waits, input logic [31:0] rdata,
                                    output int lat, output logic [31:0] rd, output logic err);
    if (waits >= TIMEOUT) begin
      lat = TIMEOUT + 2;
      rd  = '0;
      err = 1'b1;
    end else begin
      lat = 3 + waits;
      rd  = wr ? 32'h0 : rdata;
      err = 1'b0;
    end
  endfunction

  task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int waits,
                          output int lat, output logic [31:0] got_rd, output logic got_err,
                          output logic ok);
    int acc;
    int guard;
    ok = 1'b1; lat = 0; acc = 0; guard = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_wdata = wdata;
    bus.PREADY = 1'b0;
    while (!bus.cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.cmd_ready) ok = 1'b0;
    forever begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        bus.cmd_valid = 1'b0; bus.cmd_write = ~wr;
        bus.cmd_addr = $urandom; bus.cmd_wdata = $urandom;
      end
      if (bus.rsp_valid || lat > 300) break;
      if (bus.PADDR !== addr || bus.PWRITE !== wr || bus.PWDATA !== wdata) ok = 1'b0;
      if (lat == 1) begin
        if (!(bus.PSEL && !bus.PENABLE)) ok = 1'b0;
        bus.PREADY = 1'($urandom_range(0, 1));
        bus.PRDATA = $urandom;
      end else begin
        if (!(bus.PSEL && bus.PENABLE)) ok = 1'b0;
        bus.PREADY = (acc >= waits);
        bus.PRDATA = (acc >= waits) ? rdata : $urandom;
        acc++;
      end
    end
    if (bus.PSEL || bus.PENABLE) ok = 1'b0;
    got_rd = bus.rsp_rdata; got_err = bus.rsp_err;
    bus.PREADY = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t        vecs[6];
  int          lat, e_lat;
  logic [31:0] got_rd, e_rd, r_addr, r_wdata, r_rdata;
  logic        got_err, e_err, ok, r_wr, stall;
  int          r_waits, rsp_seen;
  int          acc_cyc[$];
  int          rsp_cyc[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 32'h2,  32'hA5,   32'h0,    0,  3,  32'h0,    1'b0};
    vecs[1] = '{1'b0, 32'h1,  32'h0,    32'hF,    2,  5,  32'hF,    1'b0};
    vecs[2] = '{1'b0, 32'h10, 32'h0,    32'hDEAD, 16, 18, 32'h0,    1'b1};
    vecs[3] = '{1'b0, 32'h20, 32'h0,    32'h1234, 0,  3,  32'h1234, 1'b0};
    vecs[4] = '{1'b0, 32'h30, 32'h0,    32'hCAFE, 15, 18, 32'hCAFE, 1'b0};
    vecs[5] = '{1'b1, 32'h40, 32'h55AA, 32'hFFFF, 1,  4,  32'h0,    1'b0};

    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.PREADY = 1'b0; bus.PRDATA = '0;
    #3;
    chk("reset_ctrl", 64'({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.busy, bus.cmd_ready,
                           bus.rsp_valid, bus.rsp_err}), 64'(7'b0000100));
    chk("reset_data", 64'({bus.PADDR, bus.PWDATA} | 64'(bus.rsp_rdata)), 64'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].waits,
               lat, got_rd, got_err, ok);
      chk($sformatf("vec%0d_lat", i),   64'(lat),     64'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_rdata", i), 64'(got_rd),  64'(vecs[i].exp_rdata));
      chk($sformatf("vec%0d_err", i),   64'(got_err), 64'(vecs[i].exp_err));
      chk($sformatf("vec%0d_proto", i), 64'(ok),      64'h1);
      @(negedge clk);
      chk($sformatf("vec%0d_hold", i), 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}),
          64'({1'b0, vecs[i].exp_err, vecs[i].exp_rdata}));
    end

    for (int i = 0; i < 20; i++) begin
      r_wr = 1'($urandom_range(0, 1)); r_addr = $urandom; r_wdata = $urandom; r_rdata = $urandom;
      r_waits = $urandom_range(0, 18);
      ref_model(r_wr, r_waits, r_rdata, e_lat, e_rd, e_err);
      run_xfer(r_wr, r_addr, r_wdata, r_rdata, r_waits, lat, got_rd, got_err, ok);
      chk($sformatf("rnd%0d_lat", i),   64'(lat),     64'(e_lat));
      chk($sformatf("rnd%0d_rdata", i), 64'(got_rd),  64'(e_rd));
      chk($sformatf("rnd%0d_err", i),   64'(got_err), 64'(e_err));
      chk($sformatf("rnd%0d_proto", i), 64'(ok),      64'h1);
    end

    // Back-to-back reads with cmd_valid held high
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h100;
    bus.PREADY = 1'b1; bus.PRDATA = 32'h500;
    for (int c = 0; c < 12; c++) begin
      if (bus.rsp_valid) rsp_cyc.push_back(c);
      if (bus.cmd_valid && bus.cmd_ready) begin
        acc_cyc.push_back(c);
        @(posedge clk); #1;
        if (acc_cyc.size() == 3) bus.cmd_valid = 1'b0;
        else bus.cmd_addr = bus.cmd_addr + 32'h4;
      end
      @(negedge clk);
    end
    bus.PREADY = 1'b0;
    chk("b2b_acc_count", 64'(acc_cyc.size()), 64'd3);
    chk("b2b_rsp_count", 64'(rsp_cyc.size()), 64'd3);
    chk("b2b_acc_cycles", 64'({acc_cyc[0], acc_cyc[1]}), 64'({32'd0, 32'd3}));
    chk("b2b_acc_cycle2", 64'(acc_cyc[2]), 64'd6);
    chk("b2b_rsp_cycles", 64'({rsp_cyc[0], rsp_cyc[1]}), 64'({32'd3, 32'd6}));
    chk("b2b_rsp_cycle2", 64'(rsp_cyc[2]), 64'd9);
    chk("b2b_rdata", 64'(bus.rsp_rdata), 64'h500);

    // Command arriving during ACCESS waits for IDLE
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h8; bus.PREADY = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 32'h4; bus.cmd_wdata = 32'h77;
    stall = bus.cmd_ready;
    @(negedge clk);
    stall = stall | bus.cmd_ready;
    @(negedge clk);
    stall = stall | bus.cmd_ready;
    bus.PREADY = 1'b1; bus.PRDATA = 32'h3C;
    @(negedge clk);
    chk("stall_ready_low", 64'(stall), 64'h0);
    chk("stall_rsp", 64'({bus.rsp_valid, bus.cmd_ready, bus.PADDR}), 64'({2'b11, 32'h8}));
    chk("stall_rdata", 64'(bus.rsp_rdata), 64'h3C);
    bus.PREADY = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("stall_next_setup", 64'({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR}),
        64'({3'b101, 32'h4}));
    bus.PREADY = 1'b1;
    rsp_seen = 0;
    for (int c = 0; c < 10 && rsp_seen == 0; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) rsp_seen = 1;
    end
    bus.PREADY = 1'b0;
    chk("stall_second_done", 64'(rsp_seen), 64'h1);

    // Asynchronous reset in the second ACCESS wait cycle of a write
    run_xfer(1'b0, 32'h60, 32'h0, 32'h99, 0, lat, got_rd, got_err, ok);
    chk("prereset_rdata", 64'(got_rd), 64'h99);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 32'h50; bus.cmd_wdata = 32'hBEEF;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_ctrl", 64'({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.busy, bus.cmd_ready,
                              bus.rsp_valid, bus.rsp_err}), 64'(7'b0000100));
    chk("midreset_data", 64'({bus.PADDR, bus.PWDATA} | 64'(bus.rsp_rdata)), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.PSEL) rsp_seen = 1;
    end
    chk("midreset_no_rsp", 64'(rsp_seen), 64'h0);
    run_xfer(1'b0, 32'h70, 32'h0, 32'h1357, 1, lat, got_rd, got_err, ok);
    chk("postreset_lat", 64'(lat), 64'd4);
    chk("postreset_rdata", 64'({got_err, got_rd}), 64'({1'b0, 32'h1357}));

    @(negedge clk);
    chk("protocol_monitor", 64'(viol), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
